// File: rtl/mux_scan_nto1_pkg.sv
// Shared definitions for the N-to-1 scanning multiplexer: FSM encoding
// and the select-width helper used by the top and its finder.
package mux_scan_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_SCAN_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        SCAN = ST_SCAN_ENC,
        DONE = ST_DONE_ENC
    } state_t;

    // Width needed to index n channels; never narrower than one bit.
    function automatic int sel_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_nto1_next_ch_find.sv
// Combinational priority finder: lowest set mask bit strictly above ptr.
module next_ch_find
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int SEL_W = sel_w_of(N_CH)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] nxt,
    output logic             none_left
);

    // Scan from the top down so the last hit written is the lowest index above ptr.
    always_comb begin
        nxt       = '0;
        none_left = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(ptr))) begin
                nxt       = SEL_W'(k);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// N-to-1 multiplexer with registered valid/ready output, manual select
// mode and an automatic ascending scan over a latched channel mask.
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DATA_W = 1,
    parameter int SEL_W  = sel_w_of(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic                   start,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    state_t            state, state_d;
    logic [SEL_W-1:0]  ptr, ptr_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0] data_d;
    logic [SEL_W-1:0]  sel_d;
    logic              valid_d, last_d;

    logic              free;
    logic [SEL_W-1:0]  nxt_idx;
    logic              none_left;
    logic [SEL_W-1:0]  first_above0;
    logic              first_none;
    logic [SEL_W-1:0]  first_idx;
    logic              first_any;

    // Out-of-range indices yield zero data rather than wrapping.
    function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] bus,
                                               input logic [SEL_W-1:0]       idx);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) r = bus[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    // Next channel to visit during a scan, relative to the live pointer.
    next_ch_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next (
        .mask      (mask_q),
        .ptr       (ptr),
        .nxt       (nxt_idx),
        .none_left (none_left)
    );

    // First channel of a new scan: bit 0 itself, else the next set bit above 0.
    next_ch_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
        .mask      (ch_mask),
        .ptr       ('0),
        .nxt       (first_above0),
        .none_left (first_none)
    );

    assign first_idx = ch_mask[0] ? '0 : first_above0;
    assign first_any = ch_mask[0] | ~first_none;
    assign free      = ~out_valid | out_ready;
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);

    // Next-state, pointer and output-register load decisions.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        mask_d  = mask_q;
        data_d  = out_data;
        sel_d   = out_sel;
        last_d  = out_last;
        valid_d = out_valid & ~out_ready;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (free) begin
                        data_d  = pick(in_data, sel_in);
                        sel_d   = sel_in;
                        last_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end else if (start) begin
                    // A pending manual beat is left to drain on its own.
                    mask_d = ch_mask;
                    if (first_any) begin
                        ptr_d   = first_idx;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (out_valid && out_last) begin
                    // Final beat loaded; leave only once it is taken.
                    if (out_ready) state_d = DONE;
                end else if (free) begin
                    data_d  = pick(in_data, ptr);
                    sel_d   = ptr;
                    last_d  = none_left;
                    valid_d = 1'b1;
                    if (!none_left) ptr_d = nxt_idx;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Pointer, latched mask and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mask_q    <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            ptr       <= ptr_d;
            mask_q    <= mask_d;
            out_data  <= data_d;
            out_sel   <= sel_d;
            out_valid <= valid_d;
            out_last  <= last_d;
        end
    end

endmodule
